// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage and the fetch->decode register.
package fetch_unit_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] PCINIT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              misalign;
    } fetch_out_t;

    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] p);
        return p + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction bus and fetch->decode handshake bundle.
// out_misalign exists only when FETCH_MISALIGN_EN is defined.
interface fetch_if #(
    parameter int PC_W   = fetch_unit_pkg::PC_W,
    parameter int INST_W = fetch_unit_pkg::INST_W
);
    logic              ireq_valid;
    logic [PC_W-1:0]   ireq_addr;
    logic              iresp_ok;
    logic [INST_W-1:0] iresp_data;

    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
`ifdef FETCH_MISALIGN_EN
    logic              out_misalign;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output out_valid, out_inst, out_pc, out_misalign,
        input  out_ready
    );
    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  out_valid, out_inst, out_pc, out_misalign,
        output out_ready
    );
`else
    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );
    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with one output register for decode.
// Optional FETCH_MISALIGN_EN: misaligned PCs are reported instead of fetched.
module fetch_unit #(
    parameter int PC_W   = fetch_unit_pkg::PC_W,
    parameter int INST_W = fetch_unit_pkg::INST_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_nxt,
    output logic            stallpc,
    input  logic            flush,
    input  logic [PC_W-1:0] redirect_pc,
    fetch_if.master         bus
);
    import fetch_unit_pkg::*;

    fetch_state_t state;
    fetch_out_t   out_q;
    logic         out_vld;
    logic         issue_ok;

    // Issue only when the output register is free or drains this cycle.
    assign issue_ok = !flush && (!out_vld || bus.out_ready);

    assign stallpc = !(flush || (state == WAIT && bus.iresp_ok));
    assign pc_nxt  = flush ? redirect_pc : seq_pc(pc);

    assign bus.out_valid = out_vld;
    assign bus.out_inst  = out_q.inst;
    assign bus.out_pc    = out_q.pc;

`ifdef FETCH_MISALIGN_EN
    logic mis_hold;
    logic pc_mis;
    assign pc_mis           = (pc[1:0] != 2'b00);
    assign bus.out_misalign = out_q.misalign;
`else
    logic unused_misalign;
    assign unused_misalign = out_q.misalign;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            out_vld        <= 1'b0;
            out_q          <= '0;
            bus.ireq_valid <= 1'b0;
            bus.ireq_addr  <= '0;
`ifdef FETCH_MISALIGN_EN
            mis_hold       <= 1'b0;
`endif
        end else begin
            if (out_vld && bus.out_ready)
                out_vld <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (issue_ok) begin
`ifdef FETCH_MISALIGN_EN
                        // Report once, then hold the PC until a redirect arrives.
                        if (pc_mis) begin
                            if (!mis_hold) begin
                                out_vld        <= 1'b1;
                                out_q.inst     <= '0;
                                out_q.pc       <= pc;
                                out_q.misalign <= 1'b1;
                                mis_hold       <= 1'b1;
                            end
                        end else
`endif
                        begin
                            bus.ireq_valid <= 1'b1;
                            bus.ireq_addr  <= pc;
                            state          <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.iresp_ok) begin
                        bus.ireq_valid <= 1'b0;
                        state          <= IDLE;
                        if (!flush) begin
                            out_vld        <= 1'b1;
                            out_q.inst     <= bus.iresp_data;
                            out_q.pc       <= bus.ireq_addr;
                            out_q.misalign <= 1'b0;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Request cannot be withdrawn; swallow its response.
                    if (bus.iresp_ok) begin
                        bus.ireq_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush) begin
                out_vld        <= 1'b0;
                out_q.misalign <= 1'b0;
`ifdef FETCH_MISALIGN_EN
                mis_hold       <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives pc/bus by hand, checks on the falling edge.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic        stallpc;
    logic        flush;
    logic [63:0] redirect_pc;

    fetch_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_nxt      (pc_nxt),
        .stallpc     (stallpc),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        flush           = 1'b0;
        redirect_pc     = '0;
        pc              = PCINIT;
        bus.iresp_ok    = 1'b0;
        bus.iresp_data  = '0;
        bus.out_ready   = 1'b0;

        @(negedge clk);
        chk("rst_out_valid",  bus.out_valid,  0);
        chk("rst_out_inst",   bus.out_inst,   0);
        chk("rst_out_pc",     bus.out_pc,     0);
        chk("rst_ireq_valid", bus.ireq_valid, 0);
        chk("rst_ireq_addr",  bus.ireq_addr,  0);
        chk("rst_stallpc",    stallpc,        1);
        chk("rst_pc_nxt",     pc_nxt,         64'h8000_0004);
        reset = 1'b0;

        // first fetch, 1-cycle bus
        @(negedge clk);
        chk("f1_ireq_valid", bus.ireq_valid, 1);
        chk("f1_ireq_addr",  bus.ireq_addr,  64'h8000_0000);
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = 32'h0000_0013;
        #1;
        chk("f1_stallpc_lo", stallpc, 0);
        chk("f1_pc_nxt",     pc_nxt,  64'h8000_0004);

        @(negedge clk);
        bus.iresp_ok = 1'b0;
        chk("f1_out_valid",  bus.out_valid,  1);
        chk("f1_out_inst",   bus.out_inst,   32'h13);
        chk("f1_out_pc",     bus.out_pc,     64'h8000_0000);
        chk("f1_ireq_drop",  bus.ireq_valid, 0);
        chk("f1_stallpc_hi", stallpc,        1);
        pc = 64'h8000_0004;

        // decode back-pressure: nothing issues, output holds
        repeat (5) begin
            @(negedge clk);
            chk("bp_ireq_valid", bus.ireq_valid, 0);
            chk("bp_out_valid",  bus.out_valid,  1);
            chk("bp_out_inst",   bus.out_inst,   32'h13);
            chk("bp_out_pc",     bus.out_pc,     64'h8000_0000);
            chk("bp_stallpc",    stallpc,        1);
        end
        bus.out_ready = 1'b1;

        @(negedge clk);
        chk("f2_ireq_valid", bus.ireq_valid, 1);
        chk("f2_ireq_addr",  bus.ireq_addr,  64'h8000_0004);
        chk("f2_out_valid",  bus.out_valid,  0);

        // flush while waiting; response arrives 3 cycles later and is dropped
        flush       = 1'b1;
        redirect_pc = 64'h8000_0100;
        #1;
        chk("fl_pc_nxt",  pc_nxt,  64'h8000_0100);
        chk("fl_stallpc", stallpc, 0);

        @(negedge clk);
        flush = 1'b0;
        pc    = 64'h8000_0100;
        chk("dr_ireq_valid", bus.ireq_valid, 1);
        chk("dr_ireq_addr",  bus.ireq_addr,  64'h8000_0004);

        @(negedge clk);
        @(negedge clk);
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = 32'hDEAD_BEEF;
        #1;
        chk("dr_stallpc", stallpc, 1);

        @(negedge clk);
        bus.iresp_ok = 1'b0;
        chk("dr_out_valid",  bus.out_valid,  0);
        chk("dr_ireq_valid", bus.ireq_valid, 0);

        @(negedge clk);
        chk("f3_ireq_valid", bus.ireq_valid, 1);
        chk("f3_ireq_addr",  bus.ireq_addr,  64'h8000_0100);

        // flush coincident with the response
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = 32'h1111_1111;
        flush          = 1'b1;
        redirect_pc    = 64'h8000_0200;
        #1;
        chk("fc_stallpc", stallpc, 0);
        chk("fc_pc_nxt",  pc_nxt,  64'h8000_0200);

        @(negedge clk);
        bus.iresp_ok = 1'b0;
        flush        = 1'b0;
        pc           = 64'h8000_0200;
        chk("fc_out_valid",  bus.out_valid,  0);
        chk("fc_ireq_valid", bus.ireq_valid, 0);

        @(negedge clk);
        chk("f4_ireq_valid", bus.ireq_valid, 1);
        chk("f4_ireq_addr",  bus.ireq_addr,  64'h8000_0200);

        // reset mid-request clears immediately
        reset = 1'b1;
        #1;
        chk("rm_ireq_valid", bus.ireq_valid, 0);
        chk("rm_ireq_addr",  bus.ireq_addr,  0);
        chk("rm_out_valid",  bus.out_valid,  0);
        chk("rm_out_pc",     bus.out_pc,     0);

        @(negedge clk);
        reset          = 1'b0;
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = 32'h2222_2222;
        pc             = 64'hFFFF_FFFF_FFFF_FFFC;

        // late response in IDLE ignored; wrap-around PC fetch
        @(negedge clk);
        bus.iresp_ok = 1'b0;
        chk("late_out_valid", bus.out_valid,  0);
        chk("w_ireq_valid",   bus.ireq_valid, 1);
        chk("w_ireq_addr",    bus.ireq_addr,  64'hFFFF_FFFF_FFFF_FFFC);
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = 32'h0010_0073;
        #1;
        chk("w_pc_nxt",  pc_nxt,  64'h0);
        chk("w_stallpc", stallpc, 0);

        @(negedge clk);
        bus.iresp_ok = 1'b0;
        chk("w_out_valid", bus.out_valid, 1);
        chk("w_out_inst",  bus.out_inst,  32'h0010_0073);
        chk("w_out_pc",    bus.out_pc,    64'hFFFF_FFFF_FFFF_FFFC);

`ifdef FETCH_MISALIGN_EN
        pc = 64'h8000_0002;
        @(negedge clk);
        chk("ma_ireq_valid", bus.ireq_valid,   0);
        chk("ma_out_valid",  bus.out_valid,    1);
        chk("ma_misalign",   bus.out_misalign, 1);
        chk("ma_out_pc",     bus.out_pc,       64'h8000_0002);
        chk("ma_out_inst",   bus.out_inst,     0);
        chk("ma_stallpc",    stallpc,          1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
